// File: rtl/dmem_line_ctrl.sv
// rtl/dmem_line_ctrl.sv - line-granular backing data memory with fixed access latency
// Single-outstanding req/ack handshake; inputs are captured at acceptance only.
module dmem_line_ctrl #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int LINE_W  = 256,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] rdata_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              mem_we;

  logic [LINE_W-1:0] mem [DEPTH];

  // Byte offset and bits above the index do not take part in addressing.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        ack_d  = 1'b0;
        busy_d = 1'b0;
        if (req_i) begin
          idx_d   = addr_i[5 +: IDX_W];
          we_d    = we_i;
          wdata_d = wdata_i;
          cnt_d   = 8'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = DONE;
          if (we_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
          end
        end
      end
      DONE: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset at the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ack_o   = ack_q;
  assign busy_o  = busy_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// tb/tb_dmem_line_ctrl.sv - scoreboard bench for dmem_line_ctrl at LATENCY 10 and 1
module tb_dmem_line_ctrl;

  localparam int LW = 256;
  localparam int LAT0 = 10;
  localparam int LAT1 = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req   [2];
  logic          we    [2];
  logic [31:0]   addr  [2];
  logic [LW-1:0] wdata [2];
  logic          ack   [2];
  logic          busy  [2];
  logic [LW-1:0] rdata [2];

  dmem_line_ctrl #(.DEPTH(512), .LATENCY(LAT0), .LINE_W(LW)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .busy_o(busy[0])
  );

  dmem_line_ctrl #(.DEPTH(512), .LATENCY(LAT1), .LINE_W(LW)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .busy_o(busy[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [LW-1:0] sb0 [$];
  logic [LW-1:0] sb1 [$];
  logic [LW-1:0] mm [2][512];
  logic [LW-1:0] last_rd [2];

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every ack pops the rdata value the model predicted when the access was driven.
  always @(posedge clk) begin
    #1;
    if (ack[0]) begin
      if (sb0.size() == 0) check("dut0_unexpected_ack", LW'(ack[0]), '0);
      else check("dut0_rdata_at_ack", rdata[0], sb0.pop_front());
    end
    if (ack[1]) begin
      if (sb1.size() == 0) check("dut1_unexpected_ack", LW'(ack[1]), '0);
      else check("dut1_rdata_at_ack", rdata[1], sb1.pop_front());
    end
  end

  task automatic access(input int s, input bit wr, input logic [31:0] a,
                        input logic [LW-1:0] d, input bit hold, input bit glitch);
    int idx;
    int n;
    int lat;
    bit got;
    idx = int'(a[13:5]);
    lat = (s == 0) ? LAT0 : LAT1;
    @(negedge clk);
    req[s] = 1'b1; we[s] = wr; addr[s] = a; wdata[s] = d;
    if (wr) mm[s][idx] = d;
    else last_rd[s] = mm[s][idx];
    if (s == 0) sb0.push_back(last_rd[s]);
    else sb1.push_back(last_rd[s]);
    @(posedge clk); #1;
    check("busy_after_accept", LW'(busy[s]), LW'(1));
    check("no_ack_after_accept", LW'(ack[s]), '0);
    if (glitch) begin
      @(negedge clk);
      addr[s] = 32'h0000_00E0; we[s] = ~wr; wdata[s] = {8{32'hDEAD_BEEF}};
    end
    n = 0; got = 0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (ack[s]) got = 1;
      else check("busy_in_wait", LW'(busy[s]), LW'(1));
    end
    check("ack_latency", LW'(n), LW'(lat));
    check("busy_in_ack", LW'(busy[s]), LW'(1));
    @(negedge clk);
    if (!hold) req[s] = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", LW'(ack[s]), '0);
    check("busy_drop", LW'(busy[s]), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] p, q, r, s_pat, t_pat;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; last_rd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ack", LW'(ack[i]), '0);
      check("reset_busy", LW'(busy[i]), '0);
      check("reset_rdata", rdata[i], '0);
    end
    @(negedge clk); rst = 1'b0;

    // Write then read a known pattern.
    access(0, 1'b1, 32'h0000_0040, {32{8'hA5}}, 1'b0, 1'b0);
    access(0, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

    // Offset ignored and wrap modulo 16 KiB.
    p = {8{$urandom}};
    access(0, 1'b1, 32'h0000_0020, p, 1'b0, 1'b0);
    access(0, 1'b0, 32'h0000_003F, '0, 1'b0, 1'b0);
    access(0, 1'b0, 32'h0000_4020, '0, 1'b0, 1'b0);

    // Inputs changed during WAIT are ignored.
    access(0, 1'b1, 32'h0000_0060, {8{$urandom}}, 1'b0, 1'b0);
    access(0, 1'b1, 32'h0000_00E0, {8{$urandom}}, 1'b0, 1'b0);
    access(0, 1'b0, 32'h0000_0060, '0, 1'b0, 1'b1);
    access(0, 1'b0, 32'h0000_00E0, '0, 1'b0, 1'b0);

    // Request held through ack: next access accepted two edges after ack.
    access(0, 1'b1, 32'h0000_0120, {8{$urandom}}, 1'b1, 1'b0);
    access(0, 1'b0, 32'h0000_0120, '0, 1'b0, 1'b0);

    // Reset four edges into a write of line 5 aborts it.
    q = {8{$urandom}};
    r = ~q;
    access(0, 1'b1, 32'h0000_00A0, q, 1'b0, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_00A0; wdata[0] = r;
    @(posedge clk); #1;
    check("abort_busy_accept", LW'(busy[0]), LW'(1));
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", LW'(ack[0]), '0);
    check("abort_busy", LW'(busy[0]), '0);
    check("abort_rdata", rdata[0], '0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_late_ack", LW'(ack[0]), '0);
    access(0, 1'b0, 32'h0000_00A0, '0, 1'b0, 1'b0);

    // LATENCY=1: single access then back-to-back held accesses.
    access(1, 1'b1, 32'h0000_0040, {8{$urandom}}, 1'b1, 1'b0);
    access(1, 1'b0, 32'h0000_0040, '0, 1'b1, 1'b0);
    access(1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

    // rdata holds through a write and idle time, clears on reset.
    s_pat = {8{$urandom}};
    t_pat = {8{$urandom}};
    access(0, 1'b1, 32'h0000_0200, s_pat, 1'b0, 1'b0);
    access(0, 1'b0, 32'h0000_0200, '0, 1'b0, 1'b0);
    access(0, 1'b1, 32'h0000_0220, t_pat, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("rdata_hold_idle", rdata[0], s_pat);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rdata_reset", rdata[0], '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("sb0_drained", LW'(sb0.size()), '0);
    check("sb1_drained", LW'(sb1.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
